// File: rtl/oled_frame_tx.sv
// oled_frame_tx: streams one 96x64 RGB565 frame to an SPI-style OLED panel.
//
// A frame_start pulse seen while idle fetches every pixel from the renderer
// in row-major order and shifts each 16-bit word out MSB first. An optional
// 6-byte column/row window command header can be sent ahead of the pixels.
//
// Build option:
//   OLED_CMD_HEADER_EN  defined   -> the header 15 00 5F 75 00 3F is sent
//                                    with oled_dc=0 before the pixels.
//                       undefined -> the FSM goes straight to pixel fetch and
//                                    oled_dc stays 1 for the whole frame.
//
// Parameters:
//   PIX_LAT    clk cycles from a pixel_index change to a valid color input
//   SCLK_HALF  oled_sclk half-period in clk cycles (1..15)
//   NUM_PIX    pixels per frame (6144 for the 96x64 panel)
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   frame_start  request one frame (only looked at while idle)
//   color        RGB565 pixel for the current pixel_index
//   pixel_index  pixel being fetched, 0..NUM_PIX-1
//   oled_cs_n    chip select, active low (low for the whole frame)
//   oled_sclk    serial clock, idle high; the panel samples on its rising edge
//   oled_sdin    serial data, changes only on oled_sclk falling edges
//   oled_dc      0 = command byte, 1 = pixel data
//   busy         high from frame acceptance through the frame_done cycle
//   frame_done   one-cycle pulse after the last pixel bit
//   dbg_state    current FSM state (0 IDLE, 1 HDR, 2 FETCH, 3 SHIFT, 4 DONE)
//
// Handshake: frame_start is a request qualified only by the IDLE state; a
// request while busy is dropped, not queued. color has no valid strobe: it
// is sampled once per pixel, on the last FETCH cycle, PIX_LAT cycles after
// pixel_index moved.
module oled_frame_tx #(
    parameter int PIX_LAT   = 2,
    parameter int SCLK_HALF = 1,
    parameter int NUM_PIX   = 6144
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [15:0] color,
    output logic [12:0] pixel_index,
    output logic        oled_cs_n,
    output logic        oled_sclk,
    output logic        oled_sdin,
    output logic        oled_dc,
    output logic        busy,
    output logic        frame_done,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_FETCH = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int          LAT_W    = (PIX_LAT > 1) ? $clog2(PIX_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PIX_LAT - 1);
    localparam logic [4:0]  PH_LAST  = 5'(2 * SCLK_HALF - 1);
    localparam logic [4:0]  PH_HI    = 5'(SCLK_HALF);
    localparam logic [12:0] PIX_LAST = 13'(NUM_PIX - 1);

`ifdef OLED_CMD_HEADER_EN
    localparam state_t      FIRST_ST = S_HDR;
    // First header byte is preloaded so its MSB is on sdin as sclk first falls.
    localparam logic [15:0] SR_START = 16'h1500;

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    hdr_byte = 8'h15;
            3'd1:    hdr_byte = 8'h00;
            3'd2:    hdr_byte = 8'h5F;
            3'd3:    hdr_byte = 8'h75;
            3'd4:    hdr_byte = 8'h00;
            default: hdr_byte = 8'h3F;
        endcase
    endfunction

    logic [2:0] byte_q;
`else
    localparam state_t      FIRST_ST = S_FETCH;
    localparam logic [15:0] SR_START = 16'h0000;
`endif

    state_t            state_q, state_d;
    logic [4:0]        ph_q;      // clk cycle within the current bit
    logic [3:0]        bit_q;     // bit within the current byte/word
    logic [LAT_W-1:0]  lat_q;     // cycles spent in FETCH
    logic [12:0]       pix_q;
    logic [15:0]       sr_q;      // sr_q[15] drives sdin
    logic              ph_last;

    assign ph_last = (ph_q == PH_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_start) state_d = FIRST_ST;
`ifdef OLED_CMD_HEADER_EN
            S_HDR:   if (ph_last && bit_q == 4'd7 && byte_q == 3'd5) state_d = S_FETCH;
`endif
            S_FETCH: if (lat_q == LAT_LAST) state_d = S_SHIFT;
            S_SHIFT: if (ph_last && bit_q == 4'd15)
                         state_d = (pix_q == PIX_LAST) ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: bit timing, pixel counter and shift register. The register
    // shifts at each bit boundary except after the last bit of a byte/word,
    // so sdin holds its value while sclk idles high during FETCH and only
    // ever changes together with a falling sclk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_q   <= '0;
            bit_q  <= '0;
            lat_q  <= '0;
            pix_q  <= '0;
            sr_q   <= '0;
`ifdef OLED_CMD_HEADER_EN
            byte_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    ph_q  <= '0;
                    bit_q <= '0;
                    lat_q <= '0;
                    pix_q <= '0;
`ifdef OLED_CMD_HEADER_EN
                    byte_q <= '0;
`endif
                    if (frame_start) sr_q <= SR_START;
                end
`ifdef OLED_CMD_HEADER_EN
                S_HDR: begin
                    ph_q <= ph_last ? 5'd0 : ph_q + 5'd1;
                    if (ph_last) begin
                        if (bit_q == 4'd7) begin
                            bit_q <= '0;
                            if (byte_q != 3'd5) begin
                                byte_q <= byte_q + 3'd1;
                                sr_q   <= {hdr_byte(byte_q + 3'd1), 8'h00};
                            end
                        end else begin
                            bit_q <= bit_q + 4'd1;
                            sr_q  <= {sr_q[14:0], 1'b0};
                        end
                    end
                end
`endif
                S_FETCH: begin
                    ph_q  <= '0;
                    bit_q <= '0;
                    lat_q <= lat_q + 1'b1;
                    if (lat_q == LAT_LAST) sr_q <= color;
                end
                S_SHIFT: begin
                    lat_q <= '0;
                    ph_q  <= ph_last ? 5'd0 : ph_q + 5'd1;
                    if (ph_last) begin
                        if (bit_q == 4'd15) begin
                            bit_q <= '0;
                            if (pix_q != PIX_LAST) pix_q <= pix_q + 13'd1;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                            sr_q  <= {sr_q[14:0], 1'b0};
                        end
                    end
                end
                S_DONE: pix_q <= '0;
                default: ;
            endcase
        end
    end

    // Outputs, decoded from registered state so reset acts on them at once.
    always_comb begin
        busy        = (state_q != S_IDLE);
        oled_cs_n   = (state_q == S_IDLE);
        frame_done  = (state_q == S_DONE);
        pixel_index = pix_q;
        dbg_state   = state_q;
        oled_sclk   = 1'b1;
        oled_sdin   = (state_q == S_IDLE) ? 1'b0 : sr_q[15];
        if (state_q == S_HDR || state_q == S_SHIFT)
            oled_sclk = (ph_q >= PH_HI);
`ifdef OLED_CMD_HEADER_EN
        oled_dc = !(state_q == S_IDLE || state_q == S_HDR);
`else
        oled_dc = (state_q != S_IDLE);
`endif
    end

endmodule

// File: tb/tb_oled_frame_tx.sv
// Bench for oled_frame_tx with a shortened frame (NUM_PIX=6) so complete
// frames, including the last-pixel and DONE path, fit in a short run.
module tb_oled_frame_tx;
    localparam int PIX_LAT   = 2;
    localparam int SCLK_HALF = 2;
    localparam int NUM_PIX   = 6;
`ifdef OLED_CMD_HEADER_EN
    // 96*2 header cycles + 6*(2 + 32*2) pixel cycles
    localparam int FRAME_LEN = 588;
`else
    // 6*(2 + 32*2) pixel cycles
    localparam int FRAME_LEN = 396;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [15:0] color;
    logic [12:0] pixel_index;
    logic        oled_cs_n, oled_sclk, oled_sdin, oled_dc, busy, frame_done;
    logic [2:0]  dbg_state;

    oled_frame_tx #(
        .PIX_LAT   (PIX_LAT),
        .SCLK_HALF (SCLK_HALF),
        .NUM_PIX   (NUM_PIX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .color       (color),
        .pixel_index (pixel_index),
        .oled_cs_n   (oled_cs_n),
        .oled_sclk   (oled_sclk),
        .oled_sdin   (oled_sdin),
        .oled_dc     (oled_dc),
        .busy        (busy),
        .frame_done  (frame_done),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- renderer model ----------------
    // color is garbage in the first cycle after pixel_index moves and valid
    // from the next cycle on; PIX_LAT=2 means it must be sampled then.
    logic        const_mode = 1'b0;
    logic [15:0] const_color = 16'h0000;
    logic [12:0] idx_prev = '0;

    always @(negedge clk) begin
        if (pixel_index == idx_prev)
            color = const_mode ? const_color : {3'b000, pixel_index};
        else
            color = 16'hDEAD;
        idx_prev = pixel_index;
    end

    // ---------------- serial monitor + scoreboard ----------------
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    logic [15:0] acc = '0;
    int nbits = 0, low_run = 0;
    int sclk_viol = 0, sdin_viol = 0, pix_viol = 0, dc_viol = 0, done_cnt = 0;
    logic sclk_prev = 1'b1, sdin_prev = 1'b0;

    always @(negedge clk) begin
        if (reset || oled_cs_n) begin
            acc = '0; nbits = 0; low_run = 0;
        end else begin
            if (!sclk_prev && oled_sclk) begin
                if (low_run != SCLK_HALF) sclk_viol++;
                acc = {acc[14:0], oled_sdin};
                nbits++;
                if (!oled_dc && nbits == 8) begin
                    got_q.push_back({1'b0, 8'h00, acc[7:0]});
                    nbits = 0;
                end else if (oled_dc && nbits == 16) begin
                    got_q.push_back({1'b1, acc});
                    nbits = 0;
                end
            end
            if (!oled_sclk) low_run++; else low_run = 0;
            if (oled_sdin != sdin_prev && !(sclk_prev && !oled_sclk)) sdin_viol++;
            if (pixel_index > 13'(NUM_PIX - 1)) pix_viol++;
`ifndef OLED_CMD_HEADER_EN
            if (!oled_dc) dc_viol++;
`endif
        end
        if (frame_done) done_cnt++;
        sclk_prev = oled_sclk;
        sdin_prev = oled_sdin;
    end

    task automatic build_expected(input logic cm, input logic [15:0] cc);
        logic [7:0] hdr [6];
        hdr = '{8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F};
        exp_q.delete();
`ifdef OLED_CMD_HEADER_EN
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 8'h00, hdr[i]});
`endif
        for (int n = 0; n < NUM_PIX; n++)
            exp_q.push_back({1'b1, cm ? cc : 16'(n)});
    endtask

    // ---------------- driver: one whole frame ----------------
    task automatic run_frame(input string tag, input logic cm, input logic [15:0] cc,
                             input int dup_at, input int exp_len);
        int cnt;
        logic seen;
        const_mode = cm;
        const_color = cc;
        build_expected(cm, cc);
        got_q.delete();
        done_cnt = 0; sclk_viol = 0; sdin_viol = 0; pix_viol = 0; dc_viol = 0;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        chk({tag, " busy_rise"}, 32'(busy), 32'd1);
        chk({tag, " cs_low"}, 32'(oled_cs_n), 32'd0);
        cnt = 0;
        seen = 1'b0;
        while (cnt <= exp_len + 50) begin
            @(negedge clk);
            cnt++;
            frame_start = (cnt == dup_at);
            if (frame_done) begin seen = 1'b1; break; end
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " done_cycle"}, 32'(cnt), 32'(exp_len));
        @(negedge clk) frame_start = 1'b0;
        chk({tag, " busy_after"}, 32'(busy), 32'd0);
        chk({tag, " cs_after"}, 32'(oled_cs_n), 32'd1);
        chk({tag, " pix_after"}, 32'(pixel_index), 32'd0);
        repeat (5) @(negedge clk);
        chk({tag, " idle_state"}, 32'(dbg_state), 32'd0);
        chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
        chk({tag, " word_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s word[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, " sclk_low_len"}, 32'(sclk_viol), 32'd0);
        chk({tag, " sdin_stable"}, 32'(sdin_viol), 32'd0);
        chk({tag, " pix_range"}, 32'(pix_viol), 32'd0);
`ifndef OLED_CMD_HEADER_EN
        chk({tag, " dc_high"}, 32'(dc_viol), 32'd0);
`endif
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        const_mode;
        logic [15:0] const_color;
        int          dup_at;     // frame cycle of a second frame_start, -1 = none
        int          exp_len;    // expected frame_done cycle after busy rises
    } vec_t;

    vec_t vecs[4];

    // ---------------- main sequence ----------------
    initial begin
        int k;
        vecs[0] = '{const_mode: 1'b0, const_color: 16'h0000, dup_at: -1,        exp_len: FRAME_LEN};
        vecs[1] = '{const_mode: 1'b1, const_color: 16'hF800, dup_at: -1,        exp_len: FRAME_LEN};
        vecs[2] = '{const_mode: 1'b1, const_color: 16'h5A3C, dup_at: 100,       exp_len: FRAME_LEN};
        vecs[3] = '{const_mode: 1'b0, const_color: 16'h0000, dup_at: FRAME_LEN, exp_len: FRAME_LEN};

        reset = 1'b1;
        frame_start = 1'b0;
        @(negedge clk);
        chk("rst pixel_index", 32'(pixel_index), 32'd0);
        chk("rst cs_n", 32'(oled_cs_n), 32'd1);
        chk("rst sclk", 32'(oled_sclk), 32'd1);
        chk("rst sdin", 32'(oled_sdin), 32'd0);
        chk("rst dc", 32'(oled_dc), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst frame_done", 32'(frame_done), 32'd0);
        chk("rst state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst idle busy", 32'(busy), 32'd0);
        chk("post_rst idle state", 32'(dbg_state), 32'd0);

        for (int v = 0; v < 4; v++)
            run_frame($sformatf("vec%0d", v), vecs[v].const_mode, vecs[v].const_color,
                      vecs[v].dup_at, vecs[v].exp_len);

        // Reset in the middle of pixel 3: aborts at once, no frame_done.
        const_mode = 1'b0;
        done_cnt = 0;
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        k = 0;
        while (k < 2000 && !(pixel_index == 13'd3 && oled_dc && !oled_sclk && busy)) begin
            @(negedge clk);
            k++;
        end
        chk("midrst reached_pix3", 32'(k < 2000), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst cs_n", 32'(oled_cs_n), 32'd1);
        chk("midrst sclk", 32'(oled_sclk), 32'd1);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst pixel_index", 32'(pixel_index), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst no_done", 32'(done_cnt), 32'd0);
        chk("midrst idle", 32'(dbg_state), 32'd0);
        run_frame("after_rst", 1'b0, 16'h0000, -1, FRAME_LEN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound so the bench always ends.
    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
